wb_arbiter: RTL

- Sequences the register file write port and tracks outstanding destination registers.
- Arbitrates writebacks from the ALU and the load/store unit (LSU) onto the single regfile write port with round-robin fairness.
- Keeps a per-register busy scoreboard that gates instruction issue on RAW/WAW hazards.
- Sits between the issue stage, the execution units and the regfile write port.

---
 rtl/core_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/wb_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core constants and the writeback request payload used by the ALU and LSU.
package core_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned REG_BUS_WIDTH = $clog2(DATA_WIDTH);
    localparam int unsigned NUM_REGS      = 2 ** REG_BUS_WIDTH;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_ptr_t;

    typedef struct packed {
        logic                     valid;
        logic [REG_BUS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves after a contended cycle.
module rr_arbiter2
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_lsu,
    output logic grant_alu,
    output logic grant_lsu
);

    rr_ptr_t ptr;

    always_comb begin
        grant_alu = req_alu && (!req_lsu || (ptr == RR_ALU));
        grant_lsu = req_lsu && (!req_alu || (ptr == RR_LSU));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= RR_ALU;
        end else if (req_alu && req_lsu) begin
            ptr <= (ptr == RR_ALU) ? RR_LSU : RR_ALU;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port sequencer: ALU/LSU writeback arbitration plus busy scoreboard.
module wb_arbiter
    import core_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [REG_BUS_WIDTH-1:0] issue_rs1,
    input  logic [REG_BUS_WIDTH-1:0] issue_rs2,
    input  logic [REG_BUS_WIDTH-1:0] issue_rd,
    output logic                     issue_ready,
    input  logic                     alu_valid,
    input  logic [REG_BUS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     lsu_valid,
    input  logic [REG_BUS_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    output logic                     rf_write_enable,
    output logic [REG_BUS_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]    rf_rd_data,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     err_spurious
);

    wb_req_t                alu_req;
    wb_req_t                lsu_req;
    wb_req_t                wb_sel;
    logic                   wb_fire;
    logic                   wb_write;
    logic                   issue_fire;
    logic                   spurious;
    logic [NUM_REGS-1:0]    set_mask;
    logic [NUM_REGS-1:0]    clr_mask;
    logic [NUM_REGS-1:0]    busy_next;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_alu   (alu_req.valid),
        .req_lsu   (lsu_req.valid),
        .grant_alu (alu_ready),
        .grant_lsu (lsu_ready)
    );

    // Hazard check looks only at registered busy, so clears land one cycle later.
    always_comb begin
        issue_ready = !busy[issue_rs1] && !busy[issue_rs2] && !busy[issue_rd];
        issue_fire  = issue_valid && issue_ready;

        wb_sel   = lsu_ready ? lsu_req : alu_req;
        wb_fire  = alu_ready || lsu_ready;
        wb_write = wb_fire && (wb_sel.rd != '0);
        spurious = wb_write && !busy[wb_sel.rd];

        set_mask = '0;
        clr_mask = '0;
        if (issue_fire && (issue_rd != '0)) begin
            set_mask = NUM_REGS'(1) << issue_rd;
        end
        if (wb_write) begin
            clr_mask = NUM_REGS'(1) << wb_sel.rd;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= '0;
            rf_write_enable <= 1'b0;
            rf_rd           <= '0;
            rf_rd_data      <= '0;
            err_spurious    <= 1'b0;
        end else begin
            busy            <= busy_next;
            rf_write_enable <= wb_write;
            if (wb_write) begin
                rf_rd      <= wb_sel.rd;
                rf_rd_data <= wb_sel.data;
            end
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule
